// File: rtl/wavelet_readout_scheduler.sv
// Round-robin serializer for the I/Q readouts of a wavelet filter bank: snapshots all cores on a
// sample tick and streams SYNC_WORD, the enabled cores' 4-bit readouts and an even-parity bit.
module wavelet_readout_scheduler #(
   parameter int          N_CORES   = 8,
   parameter logic [7:0]  SYNC_WORD = 8'hA5
) (
   input  logic                   clk_master,
   input  logic                   rst,
   input  logic                   sample_tick,
   input  logic [2*N_CORES-1:0]   read_out_I,
   input  logic [2*N_CORES-1:0]   read_out_Q,
   input  logic [N_CORES-1:0]     core_en,
   input  logic                   ser_ready,
   input  logic                   clr_ovf,
   output logic                   ser_data,
   output logic                   ser_valid,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   overrun,
   output logic [7:0]             ovf_count
);

   localparam int CW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_HEADER  = 2'd1,
      S_PAYLOAD = 2'd2,
      S_PARITY  = 2'd3
   } state_t;

   state_t               state_q,     state_d;
   logic [2:0]           hdr_idx_q,   hdr_idx_d;
   logic [1:0]           sub_q,       sub_d;
   logic [CW-1:0]        core_q,      core_d;
   logic [2*N_CORES-1:0] shadow_i_q,  shadow_i_d;
   logic [2*N_CORES-1:0] shadow_qd_q, shadow_qd_d;
   logic [N_CORES-1:0]   shadow_en_q, shadow_en_d;
   logic                 parity_q,    parity_d;
   logic                 valid_q,     valid_d;
   logic                 overrun_q,   overrun_d;
   logic [7:0]           ovf_cnt_q,   ovf_cnt_d;

   logic                 xfer_s;
   logic                 data_s;
   logic                 accept_s;
   logic                 drop_s;
   logic                 first_vld_s;
   logic [CW-1:0]        first_idx_s;
   logic                 next_vld_s;
   logic [CW-1:0]        next_idx_s;

   assign xfer_s = valid_q & ser_ready;

   // Lowest enabled core overall, and lowest enabled core above the current pointer.
   always_comb begin
      first_vld_s = 1'b0;
      first_idx_s = '0;
      next_vld_s  = 1'b0;
      next_idx_s  = '0;
      for (int k = N_CORES - 1; k >= 0; k--) begin
         if (shadow_en_q[k]) begin
            first_vld_s = 1'b1;
            first_idx_s = k[CW-1:0];
         end else begin
            first_vld_s = first_vld_s;
         end
         if (shadow_en_q[k] && (k > int'(core_q))) begin
            next_vld_s = 1'b1;
            next_idx_s = k[CW-1:0];
         end else begin
            next_vld_s = next_vld_s;
         end
      end
   end

   // Serial bit selection from registered state and shadow copies only.
   always_comb begin
      data_s = 1'b0;
      case (state_q)
         S_HEADER:  data_s = SYNC_WORD[hdr_idx_q];
         S_PAYLOAD: begin
            case (sub_q)
               2'd0:    data_s = shadow_i_q[{core_q, 1'b1}];
               2'd1:    data_s = shadow_i_q[{core_q, 1'b0}];
               2'd2:    data_s = shadow_qd_q[{core_q, 1'b1}];
               default: data_s = shadow_qd_q[{core_q, 1'b0}];
            endcase
         end
         S_PARITY:  data_s = parity_q;
         default:   data_s = 1'b0;
      endcase
   end

   // Frame sequencing, snapshot acceptance and overrun bookkeeping.
   always_comb begin
      state_d     = state_q;
      hdr_idx_d   = hdr_idx_q;
      sub_d       = sub_q;
      core_d      = core_q;
      shadow_i_d  = shadow_i_q;
      shadow_qd_d = shadow_qd_q;
      shadow_en_d = shadow_en_q;
      parity_d    = parity_q;
      valid_d     = valid_q;
      accept_s    = 1'b0;
      drop_s      = 1'b0;

      case (state_q)
         S_IDLE: begin
            accept_s = sample_tick;
            valid_d  = 1'b0;
         end
         S_HEADER: begin
            drop_s = sample_tick;
            if (xfer_s && (hdr_idx_q == 3'd0)) begin
               state_d = first_vld_s ? S_PAYLOAD : S_PARITY;
               core_d  = first_idx_s;
               sub_d   = 2'd0;
            end else if (xfer_s) begin
               hdr_idx_d = hdr_idx_q - 3'd1;
            end else begin
               hdr_idx_d = hdr_idx_q;
            end
         end
         S_PAYLOAD: begin
            drop_s = sample_tick;
            if (xfer_s) begin
               parity_d = parity_q ^ data_s;
               if (sub_q == 2'd3) begin
                  state_d = next_vld_s ? S_PAYLOAD : S_PARITY;
                  core_d  = next_vld_s ? next_idx_s : core_q;
                  sub_d   = 2'd0;
               end else begin
                  sub_d = sub_q + 2'd1;
               end
            end else begin
               parity_d = parity_q;
            end
         end
         S_PARITY: begin
            // A tick landing on the parity transfer starts the next frame without a gap.
            if (xfer_s) begin
               accept_s = sample_tick;
               state_d  = S_IDLE;
               valid_d  = 1'b0;
            end else begin
               drop_s = sample_tick;
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase

      if (accept_s) begin
         shadow_i_d  = read_out_I;
         shadow_qd_d = read_out_Q;
         shadow_en_d = core_en;
         state_d     = S_HEADER;
         hdr_idx_d   = 3'd7;
         sub_d       = 2'd0;
         core_d      = '0;
         parity_d    = 1'b0;
         valid_d     = 1'b1;
      end else begin
         shadow_en_d = shadow_en_d;
      end

      if (clr_ovf) begin
         overrun_d = 1'b0;
         ovf_cnt_d = 8'd0;
      end else if (drop_s) begin
         overrun_d = 1'b1;
         ovf_cnt_d = (ovf_cnt_q == 8'd255) ? ovf_cnt_q : ovf_cnt_q + 8'd1;
      end else begin
         overrun_d = overrun_q;
         ovf_cnt_d = ovf_cnt_q;
      end
   end

   // State and shadow registers with synchronous reset.
   always_ff @(posedge clk_master) begin
      if (rst) begin
         state_q     <= S_IDLE;
         hdr_idx_q   <= 3'd0;
         sub_q       <= 2'd0;
         core_q      <= '0;
         shadow_i_q  <= '0;
         shadow_qd_q <= '0;
         shadow_en_q <= '0;
         parity_q    <= 1'b0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
         ovf_cnt_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         hdr_idx_q   <= hdr_idx_d;
         sub_q       <= sub_d;
         core_q      <= core_d;
         shadow_i_q  <= shadow_i_d;
         shadow_qd_q <= shadow_qd_d;
         shadow_en_q <= shadow_en_d;
         parity_q    <= parity_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
         ovf_cnt_q   <= ovf_cnt_d;
      end
   end

   assign ser_data   = data_s;
   assign ser_valid  = valid_q;
   assign busy       = (state_q != S_IDLE);
   assign frame_done = (state_q == S_PARITY) & xfer_s;
   assign overrun    = overrun_q;
   assign ovf_count  = ovf_cnt_q;

endmodule
